ntt_addr_gen: RTL and testbench
===============================

# ntt_addr_gen

Address and select generator for the radix-2, 4-BFU NTT datapath. It steps through every stage and cycle of an in-place Cooley-Tukey NTT and computes the 8 coefficient indices consumed per cycle (4 butterflies × top/bottom). Each index is split into a bank number and an in-bank address, and the block produces the per-lane addresses plus the per-bank lane selects. It sits directly upstream of the bank-input address crossbar: its `b0..b7` and `sel_a_0..sel_a_7` drive that crossbar, so bank k receives address `b[sel_a_k]`.

## Interface
- `LOG_N`, 10: log2 of transform length N. Legal range 6..12.
- `addr_width`, `LOG_N-3`: in-bank address width. The memory has 8 banks of depth N/8.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: launch a full transform. Sampled only in IDLE.
- `en` input 1: advance enable (stall when 0). Sampled only in RUN.
- `b0..b7` output `addr_width` each: in-bank address of lane l.
- `sel_a_0..sel_a_7` output 3 each: for bank k, the lane whose bank is k.
- `stage` output `$clog2(LOG_N)`: stage of the current output vector.
- `valid` output 1: the output vector is new this cycle.
- `busy` output 1: high in RUN.
- `done` output 1: one-cycle pulse after the last vector.
- `conflict` output 1: sticky. Set if any output vector has a bank collision.

## Operation
- FSM states:
  - IDLE → RUN on `start`=1.
  - RUN → DONE when the last vector is issued.
  - DONE → IDLE unconditionally.
- Counters:
  - Cycle counter `c` runs 0..N/8-1.
  - Stage counter `s` runs 0..LOG_N-1.
  - Both clear on the IDLE→RUN transition.
- In RUN, when `en`=1:
  - Compute the vector for (s, c) and register it.
  - Increment `c`. When `c` wraps to 0, increment `s`.
  - The vector with s=LOG_N-1, c=N/8-1 is the last one. Its cycle transitions the FSM to DONE.
- In RUN, when `en`=0: counters hold, output registers hold, and `valid` for the next cycle is 0.
- Index math per lane pair k = 0..3:
  - j = c + k·(N/8)
  - p = LOG_N-1-s
  - top = ((j>>p)<<(p+1)) | (j & (2^p-1))
  - bot = top | 2^p
  - Lane 2k carries top; lane 2k+1 carries bot.
- Bank mapping for an index i: bank(i) = (sum of the 3-bit digits of i, taken from the LSB) mod 8. Address = i>>3.
  - `b_l` = address of lane l.
- Select generation, for each bank k:
  - `sel_a_k` = the lowest-numbered lane whose bank equals k.
  - If no lane maps to k, `sel_a_k` = 0.
  - If fewer than 8 distinct banks appear in one vector, set `conflict` in the same cycle as that vector's `valid`.
- `conflict` clears only on `rst` or on the IDLE→RUN transition.
- `start` while in RUN or DONE is ignored.

## Timing
- Reset values of all outputs are 0: `b0..b7`, `sel_a_*`, `stage`, `valid`, `busy`, `done`, `conflict`. The FSM resets to IDLE.
- Latency:
  - `start` is sampled at edge E0; RUN begins after E0.
  - The first `en`=1 edge E1 registers vector (0,0), so `valid`=1 during the cycle after E1.
  - Each registered vector appears one cycle after its `en`=1 edge.
  - `stage` is registered together with its vector.
- Throughput: one vector per `en`=1 cycle. A full transform is exactly LOG_N·N/8 valid cycles, 1280 at the default.
- `busy`=1 for every cycle in RUN, including stalled cycles. It is 0 in IDLE and DONE.
- `done`:
  - Pulses high for one cycle, in the cycle after the last vector's `valid`=1.
  - In that cycle `valid`=0 and outputs hold the last vector.
  - A `start` during the `done` cycle is ignored.
  - The earliest restart is the following cycle, in IDLE.
- Reset mid-run: `rst` asserts asynchronously and immediately clears all outputs and returns the FSM to IDLE. No `done` pulse is issued.
- Outputs other than `valid`, `done` and `busy` hold their last value while idle.

## Test plan
- Reset, then `start`, then `en`=1 (LOG_N=10):
  - First valid vector: `stage`=0, `b0..b7` = 0,64,16,80,32,96,48,112, `sel_a_k`=k for all k, `conflict`=0.
- Continuous `en`=1:
  - Exactly 1280 `valid` pulses occur.
  - `stage` increments every 128 valids.
  - `done` is high for exactly one cycle, immediately after the last valid.
  - `busy` falls in the same cycle `done` rises.
- Random `en` stalls (around 30 % low):
  - The valid vector sequence is identical to the unstalled run.
  - Outputs hold and `valid`=0 during stalls.
- Per-cycle compare against a software model for LOG_N=6 and LOG_N=10:
  - Check `b*`, `sel_a_*` and the `conflict` set-time against the model.
  - Check that `sel_a_k` lanes map to bank k whenever `conflict`=0.
- Assert `rst` at vector 500:
  - All outputs are 0 within the same cycle and the FSM is in IDLE.
  - A new `start` restarts at (0,0) with `conflict` cleared.
- `start` held high throughout the run and in the `done` cycle:
  - No restart occurs mid-run.
  - A second run begins only after IDLE is reached.

Source files
------------

// File: rtl/ntt_addr_gen.sv
// Address/select generator for the radix-2, 4-BFU in-place NTT: walks every (stage, cycle)
// pair and emits per-lane in-bank addresses plus per-bank lane selects for the input crossbar.
module ntt_addr_gen #(
    parameter int LOG_N      = 10,
    parameter int addr_width = LOG_N - 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     en,
    output logic [addr_width-1:0]    b0,
    output logic [addr_width-1:0]    b1,
    output logic [addr_width-1:0]    b2,
    output logic [addr_width-1:0]    b3,
    output logic [addr_width-1:0]    b4,
    output logic [addr_width-1:0]    b5,
    output logic [addr_width-1:0]    b6,
    output logic [addr_width-1:0]    b7,
    output logic [2:0]               sel_a_0,
    output logic [2:0]               sel_a_1,
    output logic [2:0]               sel_a_2,
    output logic [2:0]               sel_a_3,
    output logic [2:0]               sel_a_4,
    output logic [2:0]               sel_a_5,
    output logic [2:0]               sel_a_6,
    output logic [2:0]               sel_a_7,
    output logic [$clog2(LOG_N)-1:0] stage,
    output logic                     valid,
    output logic                     busy,
    output logic                     done,
    output logic                     conflict
);
    localparam int IW   = LOG_N;
    localparam int CW   = LOG_N - 3;
    localparam int SW   = $clog2(LOG_N);
    localparam int NDIG = (LOG_N + 2) / 3;
    localparam int DW   = 3 * NDIG;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state;
    logic [CW-1:0]         c;
    logic [SW-1:0]         s;
    logic                  finishing;
    logic [addr_width-1:0] addr_q [8];
    logic [2:0]            sel_q  [8];

    logic [IW-1:0]         idx   [8];
    logic [2:0]            bank  [8];
    logic [2:0]            sel_d [8];
    logic                  vec_conflict;

    function automatic logic [2:0] bank_of(input logic [IW-1:0] i);
        logic [DW-1:0] w;
        logic [2:0]    acc;
        w   = DW'(i);
        acc = 3'd0;
        for (int d = 0; d < NDIG; d++) acc = acc + w[3*d +: 3];
        return acc;
    endfunction

    // Butterfly pair k reads j = c + k*N/8 with a zero spliced in at bit p (top) or a one (bottom).
    always_comb begin
        logic [IW-1:0] j;
        logic [IW-1:0] low_mask;
        logic [IW-1:0] top;
        logic [7:0]    hit;
        int            p;
        p        = LOG_N - 1 - int'(s);
        low_mask = (IW'(1) << p) - IW'(1);
        hit      = 8'd0;
        for (int k = 0; k < 4; k++) begin
            j            = IW'({2'(k), c});
            top          = ((j >> p) << (p + 1)) | (j & low_mask);
            idx[2*k]     = top;
            idx[2*k + 1] = top | (IW'(1) << p);
        end
        for (int l = 0; l < 8; l++) begin
            bank[l] = bank_of(idx[l]);
            hit     = hit | (8'd1 << bank[l]);
        end
        for (int k = 0; k < 8; k++) begin
            sel_d[k] = 3'd0;
            for (int l = 7; l >= 0; l--)
                if (bank[l] == 3'(k)) sel_d[k] = 3'(l);
        end
        vec_conflict = ~&hit;
    end

    // finishing marks the cycle showing the last vector; done follows it in DONE so a start
    // during the done pulse cannot relaunch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            c         <= '0;
            s         <= '0;
            finishing <= 1'b0;
            stage     <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            conflict  <= 1'b0;
            for (int l = 0; l < 8; l++) begin
                addr_q[l] <= '0;
                sel_q[l]  <= '0;
            end
        end else begin
            valid <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        c         <= '0;
                        s         <= '0;
                        finishing <= 1'b0;
                        conflict  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    if (finishing) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (en) begin
                        valid    <= 1'b1;
                        stage    <= s;
                        conflict <= conflict | vec_conflict;
                        for (int l = 0; l < 8; l++) begin
                            addr_q[l] <= addr_width'(idx[l] >> 3);
                            sel_q[l]  <= sel_d[l];
                        end
                        c <= c + CW'(1);
                        if (&c) begin
                            if (s == SW'(LOG_N - 1)) finishing <= 1'b1;
                            else                     s <= s + SW'(1);
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign b0 = addr_q[0];
    assign b1 = addr_q[1];
    assign b2 = addr_q[2];
    assign b3 = addr_q[3];
    assign b4 = addr_q[4];
    assign b5 = addr_q[5];
    assign b6 = addr_q[6];
    assign b7 = addr_q[7];

    assign sel_a_0 = sel_q[0];
    assign sel_a_1 = sel_q[1];
    assign sel_a_2 = sel_q[2];
    assign sel_a_3 = sel_q[3];
    assign sel_a_4 = sel_q[4];
    assign sel_a_5 = sel_q[5];
    assign sel_a_6 = sel_q[6];
    assign sel_a_7 = sel_q[7];

endmodule

// File: tb/tb_ntt_addr_gen.sv
// Directed/model-based bench for ntt_addr_gen at LOG_N=10 and LOG_N=6.
module tb_ntt_addr_gen;

    typedef struct packed {
        logic         valid;
        logic         busy;
        logic         done;
        logic         conflict;
        logic [3:0]   stage;
        logic [119:0] vec;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start10 = 1'b0, en10 = 1'b0, start6 = 1'b0, en6 = 1'b0;

    logic [6:0] b10 [8];
    logic [2:0] sel10 [8];
    logic [3:0] stage10;
    logic       valid10, busy10, done10, conf10;

    logic [2:0] b6 [8];
    logic [2:0] sel6 [8];
    logic [2:0] stage6;
    logic       valid6, busy6, done6, conf6;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ntt_addr_gen #(.LOG_N(10)) u10 (
        .clk(clk), .rst(rst), .start(start10), .en(en10),
        .b0(b10[0]), .b1(b10[1]), .b2(b10[2]), .b3(b10[3]),
        .b4(b10[4]), .b5(b10[5]), .b6(b10[6]), .b7(b10[7]),
        .sel_a_0(sel10[0]), .sel_a_1(sel10[1]), .sel_a_2(sel10[2]), .sel_a_3(sel10[3]),
        .sel_a_4(sel10[4]), .sel_a_5(sel10[5]), .sel_a_6(sel10[6]), .sel_a_7(sel10[7]),
        .stage(stage10), .valid(valid10), .busy(busy10), .done(done10), .conflict(conf10)
    );

    ntt_addr_gen #(.LOG_N(6)) u6 (
        .clk(clk), .rst(rst), .start(start6), .en(en6),
        .b0(b6[0]), .b1(b6[1]), .b2(b6[2]), .b3(b6[3]),
        .b4(b6[4]), .b5(b6[5]), .b6(b6[6]), .b7(b6[7]),
        .sel_a_0(sel6[0]), .sel_a_1(sel6[1]), .sel_a_2(sel6[2]), .sel_a_3(sel6[3]),
        .sel_a_4(sel6[4]), .sel_a_5(sel6[5]), .sel_a_6(sel6[6]), .sel_a_7(sel6[7]),
        .stage(stage6), .valid(valid6), .busy(busy6), .done(done6), .conflict(conf6)
    );

    // Reference model in plain integer arithmetic: vec = {sel[7..0] (3b each), addr[7..0] (12b each)}.
    function automatic int model_index(input int logn, input int s, input int c, input int lane);
        int n8, j, p, top;
        n8  = 1 << (logn - 3);
        j   = c + (lane / 2) * n8;
        p   = logn - 1 - s;
        top = (j / (1 << p)) * (1 << (p + 1)) + (j % (1 << p));
        return (lane % 2 == 1) ? top + (1 << p) : top;
    endfunction

    function automatic int model_bank(input int i);
        int sum = 0;
        int v = i;
        while (v > 0) begin
            sum = sum + v % 8;
            v = v / 8;
        end
        return sum % 8;
    endfunction

    function automatic logic [119:0] model_vec(input int logn, input int s, input int c);
        logic [119:0] r;
        int bk [8];
        int idx, lane;
        bit found;
        r = '0;
        for (int l = 0; l < 8; l++) begin
            idx = model_index(logn, s, c, l);
            bk[l] = model_bank(idx);
            r[12*l +: 12] = 12'(idx / 8);
        end
        for (int k = 0; k < 8; k++) begin
            lane = 0;
            found = 0;
            for (int l = 0; l < 8; l++)
                if (!found && bk[l] == k) begin
                    lane = l;
                    found = 1;
                end
            r[96 + 3*k +: 3] = 3'(lane);
        end
        return r;
    endfunction

    function automatic bit model_conf(input int logn, input int s, input int c);
        bit [7:0] seen = '0;
        for (int l = 0; l < 8; l++) seen[model_bank(model_index(logn, s, c, l))] = 1'b1;
        return seen != 8'hFF;
    endfunction

    function automatic obs_t obs_of(input int logn);
        obs_t o;
        o = '0;
        for (int l = 0; l < 8; l++) begin
            if (logn == 6) begin
                o.vec[12*l +: 12]   = 12'(b6[l]);
                o.vec[96 + 3*l +: 3] = sel6[l];
            end else begin
                o.vec[12*l +: 12]   = 12'(b10[l]);
                o.vec[96 + 3*l +: 3] = sel10[l];
            end
        end
        if (logn == 6) begin
            o.valid = valid6; o.busy = busy6; o.done = done6; o.conflict = conf6; o.stage = 4'(stage6);
        end else begin
            o.valid = valid10; o.busy = busy10; o.done = done10; o.conflict = conf10; o.stage = stage10;
        end
        return o;
    endfunction

    task automatic set_start(input int logn, input bit v);
        if (logn == 6) start6 = v;
        else           start10 = v;
    endtask

    task automatic set_en(input int logn, input bit v);
        if (logn == 6) en6 = v;
        else           en10 = v;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o;
        $display("[TB] test_reset");
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        o = obs_of(10);
        n_cmp++;
        if (o !== '0) begin
            n_bad++;
            $display("[TB] FAIL reset10: got %h want 0", o);
        end
        o = obs_of(6);
        n_cmp++;
        if (o !== '0) begin
            n_bad++;
            $display("[TB] FAIL reset6: got %h want 0", o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_first_vector();
        $display("[TB] test_first_vector");
        start10 = 1'b1;
        en10 = 1'b0;
        @(posedge clk); #1;
        start10 = 1'b0;
        en10 = 1'b1;
        @(posedge clk); #1;
        en10 = 1'b0;
        n_cmp++;
        if ({valid10, busy10, done10, conf10, stage10} !== {4'b1100, 4'd0}) begin
            n_bad++;
            $display("[TB] FAIL first_ctrl: got v%b b%b d%b c%b st%0d want v1 b1 d0 c0 st0",
                     valid10, busy10, done10, conf10, stage10);
        end
        n_cmp++;
        if ({b10[7], b10[6], b10[5], b10[4], b10[3], b10[2], b10[1], b10[0]} !==
            {7'd112, 7'd48, 7'd96, 7'd32, 7'd80, 7'd16, 7'd64, 7'd0}) begin
            n_bad++;
            $display("[TB] FAIL first_addr: got %0d %0d %0d %0d %0d %0d %0d %0d want 0 64 16 80 32 96 48 112",
                     b10[0], b10[1], b10[2], b10[3], b10[4], b10[5], b10[6], b10[7]);
        end
        n_cmp++;
        if ({sel10[7], sel10[6], sel10[5], sel10[4], sel10[3], sel10[2], sel10[1], sel10[0]} !==
            {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}) begin
            n_bad++;
            $display("[TB] FAIL first_sel: got %0d %0d %0d %0d %0d %0d %0d %0d want 0..7",
                     sel10[0], sel10[1], sel10[2], sel10[3], sel10[4], sel10[5], sel10[6], sel10[7]);
        end
        pulse_reset();
    endtask

    task automatic test_full_run(input int logn, input int stall_pct, input bit hold_start);
        int n8, total, nvalid, s, c;
        bit en_bit, exp_valid, exp_conf, got_done, sel_ok;
        obs_t o, prev;
        logic [119:0] exp_vec;
        n8 = 1 << (logn - 3);
        total = logn * n8;
        nvalid = 0;
        exp_conf = 0;
        got_done = 0;
        $display("[TB] test_full_run LOG_N=%0d stall=%0d hold_start=%0d", logn, stall_pct, hold_start);
        set_start(logn, 1'b1);
        set_en(logn, 1'b0);
        @(posedge clk); #1;
        if (!hold_start) set_start(logn, 1'b0);
        o = obs_of(logn);
        n_cmp++;
        if ({o.valid, o.busy, o.done, o.conflict} !== 4'b0100) begin
            n_bad++;
            $display("[TB] FAIL start_state: got vbdc=%b want 0100", {o.valid, o.busy, o.done, o.conflict});
        end
        prev = o;
        for (int cyc = 0; cyc < 3 * total + 50; cyc++) begin
            en_bit = ($urandom_range(0, 99) >= stall_pct);
            exp_valid = (nvalid < total) ? en_bit : 1'b0;
            set_en(logn, en_bit);
            @(posedge clk); #1;
            o = obs_of(logn);
            if (o.done) begin
                got_done = 1;
                break;
            end
            n_cmp++;
            if (o.valid !== exp_valid || o.busy !== 1'b1) begin
                n_bad++;
                $display("[TB] FAIL valid_busy at vec %0d: got v%b b%b want v%b b1", nvalid, o.valid, o.busy, exp_valid);
            end
            if (o.valid && nvalid < total) begin
                s = nvalid / n8;
                c = nvalid % n8;
                exp_vec = model_vec(logn, s, c);
                exp_conf = exp_conf | model_conf(logn, s, c);
                n_cmp++;
                if (o.vec !== exp_vec || o.stage !== 4'(s) || o.conflict !== exp_conf) begin
                    n_bad++;
                    $display("[TB] FAIL vector %0d: got vec %h st %0d conf %b want vec %h st %0d conf %b",
                             nvalid, o.vec, o.stage, o.conflict, exp_vec, s, exp_conf);
                end
                if (!o.conflict) begin
                    sel_ok = 1;
                    for (int k = 0; k < 8; k++)
                        if (model_bank(model_index(logn, s, c, int'(o.vec[96 + 3*k +: 3]))) != k) sel_ok = 0;
                    n_cmp++;
                    if (!sel_ok) begin
                        n_bad++;
                        $display("[TB] FAIL sel_bank at vec %0d: got sel %h want each lane in its bank", nvalid, o.vec[119:96]);
                    end
                end
                nvalid++;
            end else if (!o.valid) begin
                n_cmp++;
                if ({o.stage, o.vec, o.conflict} !== {prev.stage, prev.vec, prev.conflict}) begin
                    n_bad++;
                    $display("[TB] FAIL stall_hold at vec %0d: got %h want %h", nvalid, o.vec, prev.vec);
                end
            end
            prev = o;
        end
        set_en(logn, 1'b0);
        n_cmp++;
        if (!got_done) begin
            n_bad++;
            $display("[TB] FAIL done_timeout: got no done after %0d valids want done after %0d", nvalid, total);
        end else begin
            n_cmp++;
            if (nvalid != total) begin
                n_bad++;
                $display("[TB] FAIL valid_count: got %0d want %0d", nvalid, total);
            end
            n_cmp++;
            if ({o.valid, o.busy} !== 2'b00 || {o.stage, o.vec, o.conflict} !== {prev.stage, prev.vec, prev.conflict}) begin
                n_bad++;
                $display("[TB] FAIL done_cycle: got v%b b%b vec %h want v0 b0 vec %h", o.valid, o.busy, o.vec, prev.vec);
            end
            @(posedge clk); #1;
            o = obs_of(logn);
            n_cmp++;
            if ({o.done, o.busy, o.valid} !== 3'b000) begin
                n_bad++;
                $display("[TB] FAIL after_done: got dbv=%b want 000", {o.done, o.busy, o.valid});
            end
            if (hold_start) begin
                @(posedge clk); #1;
                o = obs_of(logn);
                n_cmp++;
                if (o.busy !== 1'b1) begin
                    n_bad++;
                    $display("[TB] FAIL restart_from_idle: got busy %b want 1", o.busy);
                end
            end
        end
        set_start(logn, 1'b0);
        pulse_reset();
    endtask

    task automatic test_reset_mid_run();
        int nvalid;
        obs_t o;
        logic [119:0] exp_vec;
        $display("[TB] test_reset_mid_run");
        nvalid = 0;
        start10 = 1'b1;
        @(posedge clk); #1;
        start10 = 1'b0;
        en10 = 1'b1;
        for (int cyc = 0; cyc < 2000 && nvalid < 500; cyc++) begin
            @(posedge clk); #1;
            if (valid10) nvalid++;
        end
        n_cmp++;
        if (nvalid != 500) begin
            n_bad++;
            $display("[TB] FAIL reach_500: got %0d valids want 500", nvalid);
        end
        #2 rst = 1'b1;
        en10 = 1'b0;
        #1;
        o = obs_of(10);
        n_cmp++;
        if (o !== '0) begin
            n_bad++;
            $display("[TB] FAIL async_reset: got %h want 0", o);
        end
        @(negedge clk);
        rst = 1'b0;
        en10 = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({valid10, busy10, done10} !== 3'b000) begin
            n_bad++;
            $display("[TB] FAIL idle_after_reset: got vbd=%b want 000", {valid10, busy10, done10});
        end
        start10 = 1'b1;
        en10 = 1'b0;
        @(posedge clk); #1;
        start10 = 1'b0;
        en10 = 1'b1;
        @(posedge clk); #1;
        en10 = 1'b0;
        o = obs_of(10);
        exp_vec = model_vec(10, 0, 0);
        n_cmp++;
        if (o.vec !== exp_vec || o.stage !== 4'd0 || {o.valid, o.conflict} !== 2'b10) begin
            n_bad++;
            $display("[TB] FAIL restart_vector: got vec %h st %0d v%b c%b want vec %h st 0 v1 c0",
                     o.vec, o.stage, o.valid, o.conflict, exp_vec);
        end
        pulse_reset();
    endtask

    initial begin
        test_reset();
        test_first_vector();
        test_full_run(10, 0, 1'b0);
        test_full_run(10, 30, 1'b0);
        test_full_run(6, 0, 1'b0);
        test_full_run(6, 30, 1'b0);
        test_reset_mid_run();
        test_full_run(10, 0, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
